// File: rtl/expect_checker_pkg.sv
// expect_checker_pkg: shared types and defaults for the expect_checker slice.
//   state_t   - checker FSM encoding (IDLE=0, RUN=1, DONE=2)
//   lane_lo() - low bit of a channel lane inside a packed channel bus
//   DEF_*     - default parameter values for expect_checker
package expect_checker_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_NUM_CKPT = 4;
    localparam int DEF_CYC_W    = 16;
    localparam int DEF_ERR_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Channel k of a packed bus lives at [k*width +: width].
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/expect_checker_compare.sv
// ckpt_compare: NUM_CH-lane masked equality comparator.
//   obs    - observed channels, packed
//   exp_v  - expected channels, same packing
//   mask   - per-channel compare enable
//   mism   - per-channel mismatch (masked)
//   pop    - number of mismatching channels
//   low    - lowest mismatching channel (0 when none)
//   any    - at least one mismatch
module ckpt_compare
    import expect_checker_pkg::*;
#(
    parameter  int NUM_CH = DEF_NUM_CH,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int CW     = $clog2(NUM_CH + 1),
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH*DATA_W-1:0] obs,
    input  logic [NUM_CH*DATA_W-1:0] exp_v,
    input  logic [NUM_CH-1:0]        mask,
    output logic [NUM_CH-1:0]        mism,
    output logic [CW-1:0]            pop,
    output logic [IW-1:0]            low,
    output logic                     any
);

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_lane
            assign mism[k] = mask[k] &&
                (obs[lane_lo(k, DATA_W) +: DATA_W] != exp_v[lane_lo(k, DATA_W) +: DATA_W]);
        end
    endgenerate

    // Walk from the top lane down so the lowest mismatching lane wins.
    always_comb begin
        pop = '0;
        low = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            pop = pop + CW'(mism[i]);
            if (mism[i]) low = IW'(i);
        end
    end

    assign any = |mism;

endmodule

// File: rtl/expect_checker.sv
// expect_checker: checkpoint table driven output checker.
//   cfg_we/cfg_idx/cfg_cycle/cfg_exp/cfg_mask - table load, IDLE only
//   num_ckpt   - active entries, sampled on start
//   start      - begin a run from IDLE or DONE
//   obs        - observed DUT channels
//   busy/done/pass, err_cnt (saturating), timeout
//   first_fail_idx/first_fail_ch - first mismatching checkpoint/channel
// Optional: define CHECKER_CAPTURE_EN to add first_fail_val, the observed
// value of first_fail_ch at first_fail_idx.
module expect_checker
    import expect_checker_pkg::*;
#(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_CH   = DEF_NUM_CH,
    parameter  int NUM_CKPT = DEF_NUM_CKPT,
    parameter  int CYC_W    = DEF_CYC_W,
    parameter  int ERR_W    = DEF_ERR_W,
    localparam int PW       = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1,
    localparam int NW       = $clog2(NUM_CKPT + 1),
    localparam int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CW       = $clog2(NUM_CH + 1),
    localparam int EW1      = ERR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [PW-1:0]            cfg_idx,
    input  logic [CYC_W-1:0]         cfg_cycle,
    input  logic [NUM_CH*DATA_W-1:0] cfg_exp,
    input  logic [NUM_CH-1:0]        cfg_mask,
    input  logic [NW-1:0]            num_ckpt,
    input  logic                     start,
    input  logic [NUM_CH*DATA_W-1:0] obs,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_W-1:0]         err_cnt,
    output logic                     timeout,
    output logic [PW-1:0]            first_fail_idx,
`ifdef CHECKER_CAPTURE_EN
    output logic [DATA_W-1:0]        first_fail_val,
`endif
    output logic [CHW-1:0]           first_fail_ch
);

    state_t state, nxt;

    logic [CYC_W-1:0] cyc_cnt;
    logic [PW-1:0]    ptr;
    logic [NW-1:0]    n_ckpt;

    // Table RAM: intentionally not reset.
    logic [CYC_W-1:0]         tbl_cyc  [NUM_CKPT];
    logic [NUM_CH*DATA_W-1:0] tbl_exp  [NUM_CKPT];
    logic [NUM_CH-1:0]        tbl_mask [NUM_CKPT];

    logic [NUM_CH-1:0] mism;
    logic [CW-1:0]     pop;
    logic [CHW-1:0]    low;
    logic              any;

    logic             start_ok, hit, last, cyc_max, tmo_evt;
    logic [EW1-1:0]   err_sum;
    logic [ERR_W-1:0] err_next;

    ckpt_compare #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) u_cmp (
        .obs   (obs),
        .exp_v (tbl_exp[ptr]),
        .mask  (tbl_mask[ptr]),
        .mism  (mism),
        .pop   (pop),
        .low   (low),
        .any   (any)
    );

    assign start_ok = start && (state != RUN);
    assign hit      = (state == RUN) && (cyc_cnt == tbl_cyc[ptr]);
    assign last     = (NW'(ptr) == n_ckpt - NW'(1));
    assign cyc_max  = &cyc_cnt;
    // Counter exhausted with checkpoints still outstanding.
    assign tmo_evt  = (state == RUN) && cyc_max && !(hit && last);

    assign err_sum  = {1'b0, err_cnt} + EW1'(pop);
    assign err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: if (start) nxt = (num_ckpt == '0) ? DONE : RUN;
            RUN:        if ((hit && last) || cyc_max) nxt = DONE;
            default:    nxt = IDLE;
        endcase
    end

    // Writes land at the same edge a start is taken, so a run always sees them.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE) begin
            tbl_cyc[cfg_idx]  <= cfg_cycle;
            tbl_exp[cfg_idx]  <= cfg_exp;
            tbl_mask[cfg_idx] <= cfg_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt        <= '0;
            ptr            <= '0;
            n_ckpt         <= '0;
            err_cnt        <= '0;
            timeout        <= 1'b0;
            first_fail_idx <= '0;
            first_fail_ch  <= '0;
`ifdef CHECKER_CAPTURE_EN
            first_fail_val <= '0;
`endif
        end else if (start_ok) begin
            cyc_cnt        <= '0;
            ptr            <= '0;
            n_ckpt         <= num_ckpt;
            err_cnt        <= '0;
            timeout        <= 1'b0;
            first_fail_idx <= '0;
            first_fail_ch  <= '0;
`ifdef CHECKER_CAPTURE_EN
            first_fail_val <= '0;
`endif
        end else if (state == RUN) begin
            cyc_cnt <= cyc_cnt + 1'b1;
            if (hit) begin
                err_cnt <= err_next;
                // err_cnt is still zero only until the first mismatch of the run.
                if (any && err_cnt == '0) begin
                    first_fail_idx <= ptr;
                    first_fail_ch  <= low;
`ifdef CHECKER_CAPTURE_EN
                    first_fail_val <= obs[int'(low) * DATA_W +: DATA_W];
`endif
                end
                if (!last) ptr <= ptr + 1'b1;
            end
            if (tmo_evt) timeout <= 1'b1;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (err_cnt == '0) && !timeout;

endmodule

// File: tb/tb_expect_checker.sv
module tb_expect_checker;

    localparam logic [31:0] EXP0   = 32'h0000_0030;  // a=48
    localparam logic [31:0] EXP1   = 32'h0026_2730;  // a=48 b=39 c=38 d=0
    localparam logic [31:0] B40    = 32'h0026_2830;  // b=40
    localparam logic [31:0] BWRONG = 32'h0000_0530;  // a=48 b=5
    localparam logic [31:0] ALL1   = 32'h0101_0101;

    typedef struct {
        string      name;
        int         done_c;
        logic       pass;
        logic [7:0] err;
        logic       tmo;
        logic [1:0] ffi;
        logic [1:0] ffc;
        logic [7:0] ffv;
    } exp_t;

    exp_t sbq[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [7:0]  cfg_cycle;
    logic [31:0] cfg_exp;
    logic [3:0]  cfg_mask;
    logic [2:0]  num_ckpt;
    logic        start;
    logic [31:0] obs;
    logic        busy, done, pass, timeout;
    logic [7:0]  err_cnt;
    logic [1:0]  ffi, ffc;
`ifdef CHECKER_CAPTURE_EN
    logic [7:0]  ffv;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    expect_checker #(.DATA_W(8), .NUM_CH(4), .NUM_CKPT(4), .CYC_W(8), .ERR_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_cycle      (cfg_cycle),
        .cfg_exp        (cfg_exp),
        .cfg_mask       (cfg_mask),
        .num_ckpt       (num_ckpt),
        .start          (start),
        .obs            (obs),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .timeout        (timeout),
        .first_fail_idx (ffi),
`ifdef CHECKER_CAPTURE_EN
        .first_fail_val (ffv),
`endif
        .first_fail_ch  (ffc)
    );

    task automatic write_entry(input logic [1:0] idx, input logic [7:0] cyc,
                               input logic [31:0] ex, input logic [3:0] m);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = idx; cfg_cycle = cyc; cfg_exp = ex; cfg_mask = m;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic push(input string nm, input int dc, input logic p, input logic [7:0] er,
                        input logic tm, input logic [1:0] fi, input logic [1:0] fc,
                        input logic [7:0] fv);
        exp_t e;
        e.name = nm; e.done_c = dc; e.pass = p; e.err = er; e.tmo = tm;
        e.ffi = fi; e.ffc = fc; e.ffv = fv;
        sbq.push_back(e);
    endtask

    // Caller has raised start; obs = oa before cycle sw, ob from then on.
    task automatic run_check(input logic [31:0] oa, input logic [31:0] ob,
                             input int sw, input int budget);
        exp_t e;
        int   c;
        bit   got;
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        c = 0;
        got = done;
        while (!got && c < budget) begin
            obs = (c < sw) ? oa : ob;
            @(negedge clk);
            c++;
            if (c == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++; $display("FAIL busy_in_run: got %b want 1", busy);
                end
            end
            got = done;
        end
        e = sbq.pop_front();
        checks++;
        if (!got) begin
            errors++; $display("FAIL %s done_wait: no done within %0d cycles", e.name, budget);
        end else begin
            if (c != e.done_c) begin
                errors++; $display("FAIL %s done_cycle: got %0d want %0d", e.name, c, e.done_c);
            end
        end
        checks++;
        if (pass !== e.pass) begin
            errors++; $display("FAIL %s pass: got %b want %b", e.name, pass, e.pass);
        end
        checks++;
        if (err_cnt !== e.err) begin
            errors++; $display("FAIL %s err_cnt: got %0d want %0d", e.name, err_cnt, e.err);
        end
        checks++;
        if (timeout !== e.tmo) begin
            errors++; $display("FAIL %s timeout: got %b want %b", e.name, timeout, e.tmo);
        end
        checks++;
        if (ffi !== e.ffi || ffc !== e.ffc) begin
            errors++;
            $display("FAIL %s first_fail: got idx=%0d ch=%0d want idx=%0d ch=%0d",
                     e.name, ffi, ffc, e.ffi, e.ffc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_after_done: got %b want 0", e.name, busy);
        end
`ifdef CHECKER_CAPTURE_EN
        checks++;
        if (ffv !== e.ffv) begin
            errors++; $display("FAIL %s first_fail_val: got %0d want %0d", e.name, ffv, e.ffv);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_cycle = '0; cfg_exp = '0;
        cfg_mask = '0; num_ckpt = '0; start = 1'b0; obs = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, pass, timeout} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, timeout});
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_err: got %0d want 0", err_cnt);
        end
        checks++;
        if (ffi !== 2'd0 || ffc !== 2'd0) begin
            errors++; $display("FAIL reset_first_fail: got %0d/%0d want 0/0", ffi, ffc);
        end
        rst = 1'b0;
    endtask

    task automatic load_main_and_start();
        write_entry(2'd0, 8'd50, EXP0, 4'b1111);
        // Entry 1 written in the same cycle as start.
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_cycle = 8'd89; cfg_exp = EXP1; cfg_mask = 4'b1111;
        num_ckpt = 3'd2; start = 1'b1;
    endtask

    task automatic test_match();
        load_main_and_start();
        push("match", 90, 1'b1, 8'd0, 1'b0, 2'd0, 2'd0, 8'd0);
        run_check(EXP0, EXP1, 60, 200);
    endtask

    task automatic test_single_mismatch();
        push("b_mis", 90, 1'b0, 8'd1, 1'b0, 2'd1, 2'd1, 8'd40);
        kick();
        run_check(EXP0, B40, 60, 200);
    endtask

    task automatic test_mask();
        do_reset();
        write_entry(2'd0, 8'd50, EXP0, 4'b0001);
        write_entry(2'd1, 8'd89, EXP1, 4'b1111);
        num_ckpt = 3'd2;
        push("mask", 90, 1'b0, 8'd4, 1'b0, 2'd1, 2'd0, 8'd1);
        kick();
        run_check(BWRONG, ALL1, 60, 200);
    endtask

    task automatic test_timeout();
        do_reset();
        write_entry(2'd0, 8'd20, EXP0, 4'b1111);
        write_entry(2'd1, 8'd10, EXP1, 4'b1111);
        num_ckpt = 3'd2;
        push("timeout", 256, 1'b0, 8'd0, 1'b1, 2'd0, 2'd0, 8'd0);
        kick();
        run_check(EXP0, EXP0, 1000, 300);
    endtask

    task automatic test_abort();
        int c;
        do_reset();
        load_main_and_start();
        @(negedge clk);
        start = 1'b0; cfg_we = 1'b0;
        c = 0;
        while (c < 30) begin
            obs = EXP0;
            @(negedge clk);
            c++;
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL abort_flags: got busy=%b done=%b want 0/0", busy, done);
        end
        checks++;
        if (err_cnt !== 8'd0 || pass !== 1'b0) begin
            errors++; $display("FAIL abort_err: got err=%0d pass=%b want 0/0", err_cnt, pass);
        end
        @(negedge clk);
        rst = 1'b0;
        load_main_and_start();
        push("rerun", 90, 1'b1, 8'd0, 1'b0, 2'd0, 2'd0, 8'd0);
        run_check(EXP0, EXP1, 60, 200);
    endtask

    task automatic test_zero_and_restart();
        num_ckpt = 3'd0;
        push("zero", 0, 1'b1, 8'd0, 1'b0, 2'd0, 2'd0, 8'd0);
        kick();
        run_check(EXP0, EXP0, 0, 5);
        // A write attempted in DONE must not reach the table.
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_cycle = 8'd5; cfg_exp = 32'h0; cfg_mask = 4'b1111;
        @(negedge clk);
        cfg_we = 1'b0;
        num_ckpt = 3'd2;
        push("restart", 90, 1'b1, 8'd0, 1'b0, 2'd0, 2'd0, 8'd0);
        kick();
        run_check(EXP0, EXP1, 60, 200);
    endtask

    initial begin
        test_reset();
        test_match();
        test_single_mismatch();
        test_mask();
        test_timeout();
        test_abort();
        test_zero_and_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/expect_checker.md
Name: expect_checker

Overview:
Synthesizable checker for generated designs: the consumer end of the DUT-output/expected-value interface that our testbenches drive in simulation.
- Holds a table of checkpoints: cycle index, per-channel expected values and a per-channel enable mask.
- Counts cycles from a start pulse, compares the observed channels at each checkpoint, and accumulates errors.
- Sits beside a generated top on FPGA or in a wrapper, reporting done/pass in place of a behavioural bench.

Parameters:
DATA_W, 8, width of each observed channel
NUM_CH, 4, number of observed channels
NUM_CKPT, 4, checkpoint table depth
CYC_W, 16, cycle counter width
ERR_W, 8, error counter width (saturating)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
cfg_we  input  1  table write strobe; honoured only in IDLE
cfg_idx  input  $clog2(NUM_CKPT)  table entry written
cfg_cycle  input  CYC_W  checkpoint cycle index
cfg_exp  input  NUM_CH*DATA_W  expected values; channel k at bits [k*DATA_W +: DATA_W]
cfg_mask  input  NUM_CH  per-channel compare enable
num_ckpt  input  $clog2(NUM_CKPT+1)  active entries; sampled on start
start  input  1  begin run; honoured in IDLE or DONE
obs  input  NUM_CH*DATA_W  DUT outputs, same packing as cfg_exp
busy  output  1  high in RUN
done  output  1  high in DONE
pass  output  1  valid when done: err_cnt==0 and no timeout
err_cnt  output  ERR_W  mismatching channel count, saturating
timeout  output  1  cycle counter hit all-ones before the last checkpoint
first_fail_idx  output  $clog2(NUM_CKPT)  checkpoint of first mismatch
first_fail_ch  output  $clog2(NUM_CH)  lowest mismatching channel at that checkpoint

Behaviour:
- Reset: state IDLE; all outputs 0; cyc_cnt=0; ptr=0; table contents undefined (no reset on table RAM).
- FSM states IDLE, RUN, DONE.
- IDLE:
  - cfg_we writes the table entry.
  - start moves to RUN with cyc_cnt=0, ptr=0, and err_cnt, timeout and first_fail_* cleared.
  - If num_ckpt==0, start moves directly to DONE with pass=1.
- RUN:
  - Every cycle, cyc_cnt increments (the first RUN cycle is cycle 0).
  - When cyc_cnt==cycle[ptr]: compare obs against exp[ptr] for the channels in mask[ptr].
  - err_cnt adds the popcount of mismatches, saturating at 2^ERR_W-1.
  - On the first mismatch of the run, latch first_fail_idx=ptr and first_fail_ch=lowest mismatching channel.
  - ptr then increments; when ptr reaches num_ckpt-1 and that checkpoint is evaluated, the next state is DONE.
  - Checkpoints are evaluated in table order. An entry whose cycle is ≤ the previous entry's cycle is never matched and produces a timeout.
  - If cyc_cnt==all-ones and checkpoints remain, the next state is DONE with timeout=1.
- DONE:
  - Outputs hold.
  - start restarts the run (same behaviour as start from IDLE).
  - cfg_we is ignored in DONE; the only return path to IDLE for reload is rst.
- Simultaneous events:
  - cfg_we and start in the same IDLE cycle: the write lands first and start uses the new table.
  - start while in RUN is ignored.
  - rst during RUN aborts immediately to IDLE and clears all outputs.
- Comparison is combinational on obs in the matching cycle; results are registered, so err_cnt, first_fail_* and done update one cycle after the checkpoint.
- Width rule: cfg_cycle is compared at full CYC_W with no truncation.

Optional Feature:
CHECKER_CAPTURE_EN
- Defined: adds output first_fail_val [DATA_W], holding the observed value of first_fail_ch at first_fail_idx. It is cleared on reset and on start.
- Undefined: the port and register are absent and all other behaviour is identical.

Decomposition:
- Package expect_checker_pkg holds:
  - the state enum (IDLE=0, RUN=1, DONE=2);
  - the lane-slice helper function;
  - the default parameter constants.
- Sub-module ckpt_compare: a NUM_CH-lane masked comparator producing the mismatch vector, popcount and lowest-index. It is instantiated once.

Test Plan:
1. Table {cyc 50: a=48, others 0, mask 1111; cyc 89: a=48, b=39, c=38, d=0}, DUT obs matching, start -> done one cycle after cycle 89, pass=1, err_cnt=0.
2. Same table, obs b=40 at cycle 89 -> err_cnt=1, first_fail_idx=1, first_fail_ch=1, pass=0; with CHECKER_CAPTURE_EN, first_fail_val=40.
3. Mask 0001 at cycle 50 with b wrong -> no error counted; then all four channels wrong at cycle 89 under mask 1111 -> err_cnt=4.
4. Entry1 cycle=10 following entry0 cycle=20, CYC_W=8 -> timeout=1 at cyc_cnt=255, pass=0.
5. rst asserted at cycle 30 of a run -> busy=0, done=0, err_cnt=0 asynchronously; a new start reruns cleanly with pass=1.
6. num_ckpt=0 plus start -> done=1 and pass=1 the next cycle; a second start from DONE reruns with the table unchanged.
